// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer sharing one memory port between
// instruction fetch (IF, word reads) and load/store (DM, byte/half/word, read or write).
// Each grant issues a one-cycle memory request, then completes on the memory's send
// pulse or on a timeout. All outputs are registered.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [2:0]  dm_bhw,
  input  logic [31:0] dm_adr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_request,
  output logic [2:0]  mem_bhw,
  output logic        mem_wr,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_dataout,
  input  logic        mem_send
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  // Counter value in WAIT at which the transaction is abandoned.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_dm_q, last_dm_d;  // 1: DM was granted most recently
  logic        gnt_dm_q, gnt_dm_d;    // port owning the transaction in flight
  logic        grant_if, grant_dm, size_ok;
  logic        mem_request_d, mem_wr_d, if_done_d, dm_done_d, rsp_err_d;
  logic [2:0]  mem_bhw_d;
  logic [31:0] mem_adr_d, mem_data_d, rsp_data_d;

  assign size_ok  = (dm_bhw == 3'b001) || (dm_bhw == 3'b010) || (dm_bhw == 3'b100);
  // On a tie the port that did not win last time is granted.
  assign grant_if = if_req && (!dm_req || last_dm_q);
  assign grant_dm = dm_req && (!if_req || !last_dm_q);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (grant_if)      state_d = StIssue;
        else if (grant_dm) state_d = size_ok ? StIssue : StDone;
      end
      StIssue: state_d = StWait;
      StWait:  if (mem_send || (cnt_q == CntLast)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, counter and grant bookkeeping.
  always_comb begin
    mem_request_d = 1'b0;
    if_done_d     = 1'b0;
    dm_done_d     = 1'b0;
    mem_bhw_d     = mem_bhw;
    mem_wr_d      = mem_wr;
    mem_adr_d     = mem_adr;
    mem_data_d    = mem_data;
    rsp_data_d    = rsp_data;
    rsp_err_d     = rsp_err;
    cnt_d         = cnt_q;
    last_dm_d     = last_dm_q;
    gnt_dm_d      = gnt_dm_q;
    case (state_q)
      StIdle: begin
        if (grant_if) begin
          last_dm_d     = 1'b0;
          gnt_dm_d      = 1'b0;
          mem_adr_d     = if_adr;
          mem_bhw_d     = 3'b100;
          mem_wr_d      = 1'b0;
          mem_data_d    = '0;
          mem_request_d = 1'b1;
        end else if (grant_dm) begin
          last_dm_d = 1'b1;
          gnt_dm_d  = 1'b1;
          if (size_ok) begin
            mem_adr_d     = dm_adr;
            mem_bhw_d     = dm_bhw;
            mem_wr_d      = dm_wr;
            mem_data_d    = dm_wdata;
            mem_request_d = 1'b1;
          end else begin
            // Bad size never reaches memory; complete immediately with error.
            dm_done_d  = 1'b1;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end
        end
      end
      StIssue: cnt_d = '0;
      StWait: begin
        // A send in the expiry cycle still completes the access normally.
        if (mem_send) begin
          rsp_data_d = mem_wr ? '0 : mem_dataout;
          rsp_err_d  = 1'b0;
          if_done_d  = !gnt_dm_q;
          dm_done_d  = gnt_dm_q;
        end else if (cnt_q == CntLast) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          if_done_d  = !gnt_dm_q;
          dm_done_d  = gnt_dm_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Output, counter and grant registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_request <= 1'b0;
      mem_bhw     <= '0;
      mem_wr      <= 1'b0;
      mem_adr     <= '0;
      mem_data    <= '0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      cnt_q       <= '0;
      last_dm_q   <= 1'b1;
      gnt_dm_q    <= 1'b0;
    end else begin
      mem_request <= mem_request_d;
      mem_bhw     <= mem_bhw_d;
      mem_wr      <= mem_wr_d;
      mem_adr     <= mem_adr_d;
      mem_data    <= mem_data_d;
      if_done     <= if_done_d;
      dm_done     <= dm_done_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
      cnt_q       <= cnt_d;
      last_dm_q   <= last_dm_d;
      gnt_dm_q    <= gnt_dm_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte-array memory stub answers requests after a chosen
// delay, and a transaction-level model predicts port, latency, data and error.
module tb_mem_arbiter;
  localparam int unsigned TO = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_adr = '0;
  logic        if_done;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [2:0]  dm_bhw = '0;
  logic [31:0] dm_adr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_done;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_request;
  logic [2:0]  mem_bhw;
  logic        mem_wr;
  logic [31:0] mem_adr;
  logic [31:0] mem_data;
  logic [31:0] mem_dataout = '0;
  logic        mem_send = 1'b0;

  int checks = 0;
  int errors = 0;
  int mem_delay = 1;   // 0: never send; otherwise send this many cycles after request
  int countdown = 0;
  logic [7:0]  smem [256];  // stub memory contents
  logic [7:0]  rmem [256];  // reference memory contents
  logic [31:0] sdata = '0;
  bit          exp_last_dm = 1'b1;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_adr(if_adr), .if_done(if_done),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_bhw(dm_bhw), .dm_adr(dm_adr),
    .dm_wdata(dm_wdata), .dm_done(dm_done),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_request(mem_request), .mem_bhw(mem_bhw), .mem_wr(mem_wr),
    .mem_adr(mem_adr), .mem_data(mem_data),
    .mem_dataout(mem_dataout), .mem_send(mem_send)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] b);
    return (b == 3'b001) ? 1 : (b == 3'b010) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] adr, input int nb);
    logic [31:0] v = '0;
    logic [7:0] idx;
    for (int i = 0; i < nb; i++) begin
      idx = adr[7:0] + 8'(i);
      v[8*i +: 8] = rmem[idx];
    end
    return v;
  endfunction

  function automatic logic [2:0] legal_bhw();
    int r = $urandom_range(0, 2);
    return (r == 0) ? 3'b001 : (r == 1) ? 3'b010 : 3'b100;
  endfunction

  // Memory stub: acts on a request in its cycle, sends after mem_delay cycles.
  always @(posedge CLK) begin
    logic [7:0] idx;
    #1;
    mem_send    = 1'b0;
    mem_dataout = $urandom;
    if (RST) begin
      countdown = 0;
    end else begin
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          mem_send    = 1'b1;
          mem_dataout = sdata;
        end
      end
      if (mem_request) begin
        sdata = mem_wr ? $urandom : 32'h0;
        for (int i = 0; i < nbytes(mem_bhw); i++) begin
          idx = mem_adr[7:0] + 8'(i);
          if (mem_wr) smem[idx] = mem_data[8*i +: 8];
          else        sdata[8*i +: 8] = smem[idx];
        end
        countdown = mem_delay;
      end
    end
  end

  // One transaction on one port, started in an IDLE cycle; leaves the DUT in IDLE.
  task automatic do_txn(input bit is_dm, input logic [31:0] adr, input bit wr,
                        input logic [2:0] bhw, input logic [31:0] wdata, input int dly);
    bit legal, err_e, got, wr_e;
    int lat_e, nb, n, nreq, req_at;
    logic [31:0] data_e, wd_e, adr_at_req;
    logic [2:0] bhw_e;
    logic [7:0] idx;
    legal = !is_dm || (bhw == 3'b001) || (bhw == 3'b010) || (bhw == 3'b100);
    bhw_e = is_dm ? bhw : 3'b100;
    wr_e  = is_dm ? wr : 1'b0;
    wd_e  = is_dm ? wdata : 32'h0;
    nb    = nbytes(bhw_e);
    if (!legal) begin
      lat_e = 1; err_e = 1'b1; data_e = '0;
    end else if (dly >= 1 && dly <= int'(TO)) begin
      lat_e = dly + 2; err_e = 1'b0; data_e = wr_e ? 32'h0 : ref_read(adr, nb);
    end else begin
      lat_e = int'(TO) + 2; err_e = 1'b1; data_e = '0;
    end
    if (legal && wr_e)
      for (int i = 0; i < nb; i++) begin
        idx = adr[7:0] + 8'(i);
        rmem[idx] = wd_e[8*i +: 8];
      end
    mem_delay = dly;
    if (is_dm) begin
      dm_req = 1'b1; dm_adr = adr; dm_wr = wr; dm_bhw = bhw; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_adr = adr;
    end
    n = 0; nreq = 0; req_at = 0; got = 1'b0; adr_at_req = '0;
    while (!got && n < int'(TO) + 10) begin
      @(posedge CLK); #1; n++;
      if (n == 1) begin
        // Inputs changed after grant must not affect the transaction.
        if_adr = $urandom; dm_adr = $urandom; dm_wdata = $urandom;
        dm_bhw = 3'($urandom); dm_wr = 1'($urandom);
      end
      if (mem_request) begin nreq++; req_at = n; adr_at_req = mem_adr; end
      if (if_done || dm_done) got = 1'b1;
    end
    check_eq("latency", n, lat_e);
    check_eq("done_port", {30'd0, dm_done, if_done}, is_dm ? 32'd2 : 32'd1);
    check_eq("rsp_data", rsp_data, data_e);
    check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, err_e});
    check_eq("req_count", nreq, legal ? 32'd1 : 32'd0);
    if (legal) begin
      check_eq("req_cycle", req_at, 1);
      check_eq("mem_adr_issue", adr_at_req, adr);
      check_eq("mem_adr_hold", mem_adr, adr);
      check_eq("mem_bhw", {29'd0, mem_bhw}, {29'd0, bhw_e});
      check_eq("mem_wr", {31'd0, mem_wr}, {31'd0, wr_e});
      check_eq("mem_data", mem_data, wd_e);
    end
    if_req = 1'b0; dm_req = 1'b0;
    exp_last_dm = is_dm;
    @(posedge CLK); #1;
  endtask

  // Both ports request continuously; grants must alternate.
  task automatic do_contention(input int ntx, input int dly);
    logic [31:0] ia, da, exp_d;
    logic [2:0] db;
    int n, last_req, cur_req;
    bit got, want_dm;
    ia = $urandom; da = $urandom; db = legal_bhw();
    mem_delay = dly;
    if_req = 1'b1; if_adr = ia;
    dm_req = 1'b1; dm_adr = da; dm_wr = 1'b0; dm_bhw = db; dm_wdata = $urandom;
    n = 0; last_req = 0;
    for (int k = 0; k < ntx; k++) begin
      want_dm = !exp_last_dm;
      got = 1'b0; cur_req = -100;
      for (int c = 0; c < int'(TO) + 10 && !got; c++) begin
        @(posedge CLK); #1; n++;
        if (mem_request) cur_req = n;
        if (if_done || dm_done) got = 1'b1;
      end
      exp_d = want_dm ? ref_read(da, nbytes(db)) : ref_read(ia, 4);
      check_eq("rr_port", {30'd0, dm_done, if_done}, want_dm ? 32'd2 : 32'd1);
      check_eq("rr_data", rsp_data, exp_d);
      // Request -> send (dly) -> DONE (+1) -> IDLE (+1) -> next request (+1).
      if (k > 0) check_eq("rr_spacing", cur_req - last_req, dly + 3);
      last_req = cur_req;
      exp_last_dm = want_dm;
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [2:0] bad [5];
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      smem[i] = b; rmem[i] = b;
    end
    smem[8'h10] = 8'h93; smem[8'h11] = 8'h00; smem[8'h12] = 8'hA0; smem[8'h13] = 8'h00;
    rmem[8'h10] = 8'h93; rmem[8'h11] = 8'h00; rmem[8'h12] = 8'hA0; rmem[8'h13] = 8'h00;

    // Reset held with both requests pending.
    RST = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_bhw = 3'b100;
    repeat (3) begin
      @(posedge CLK); #1;
      check_eq("rst_mem_request", {31'd0, mem_request}, 32'd0);
      check_eq("rst_done", {30'd0, dm_done, if_done}, 32'd0);
      check_eq("rst_mem_bhw", {29'd0, mem_bhw}, 32'd0);
      check_eq("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      check_eq("rst_mem_adr", mem_adr, 32'd0);
      check_eq("rst_mem_data", mem_data, 32'd0);
      check_eq("rst_rsp_data", rsp_data, 32'd0);
      check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    end
    RST = 1'b0; if_req = 1'b0; dm_req = 1'b0; exp_last_dm = 1'b1;

    do_contention(4, 1);

    do_txn(1'b0, 32'h0000_0010, 1'b0, 3'b100, 32'h0, 1);
    check_eq("if_word", rsp_data, 32'h00A0_0093);
    do_txn(1'b1, 32'h0000_1000, 1'b1, 3'b010, 32'h0000_BEEF, 1);
    do_txn(1'b1, 32'h0000_1001, 1'b0, 3'b001, 32'h0, 1);
    check_eq("dm_byte", rsp_data, 32'h0000_00BE);
    do_txn(1'b1, 32'h0000_0020, 1'b0, 3'b011, 32'h0, 1);
    do_txn(1'b0, 32'h0000_0030, 1'b0, 3'b100, 32'h0, 0);

    // Reset while waiting for a send that never comes.
    mem_delay = 0; if_req = 1'b1; if_adr = 32'h40;
    @(posedge CLK); #1;
    check_eq("abort_req", {31'd0, mem_request}, 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1; if_req = 1'b0;
    @(posedge CLK); #1;
    check_eq("abort_mem_request", {31'd0, mem_request}, 32'd0);
    check_eq("abort_done", {30'd0, dm_done, if_done}, 32'd0);
    RST = 1'b0; exp_last_dm = 1'b1;
    do_txn(1'b0, 32'h0000_0044, 1'b0, 3'b100, 32'h0, 1);
    do_contention(3, 2);

    for (int t = 0; t < 40; t++) begin
      bit pdm;
      logic [2:0] sz;
      pdm = 1'($urandom);
      sz  = ($urandom_range(0, 7) == 0) ? bad[$urandom_range(0, 4)] : legal_bhw();
      do_txn(pdm, $urandom, 1'($urandom), sz, $urandom, $urandom_range(0, TO + 1));
      if ($urandom_range(0, 7) == 0) do_contention(2, $urandom_range(1, TO));
      if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
